rotary_encoder_ctrl: RTL and testbench
======================================

Name: rotary_encoder_ctrl

Overview:
Parametrised quadrature rotary-encoder front end: synchroniser, per-input debounce, full-detent quadrature decoding and a bounded position register. Range is configurable, with saturate or wrap at the limits. Push-button press is debounced, emitted as a one-cycle event, and can optionally reload the position. Sits between the board encoder pins and the mode/gear logic that consumes `pos`, the step pulses and `btn_press`.

Parameters:
DB_TICKS, 250000, consecutive stable cycles required before a debounced level changes (10 ms at 25 MHz); minimum 2.
POS_W, 3, width of the position output.
POS_MIN, 0, lowest position value.
POS_MAX, 6, highest position value; must satisfy POS_MIN < POS_MAX < 2^POS_W.
POS_INIT, 3, position after reset and after a button reload.
WRAP, 0, 0 = saturate at limits; 1 = wrap POS_MAX<->POS_MIN.
BTN_RELOAD, 1, 1 = a debounced button press loads POS_INIT into pos.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous active-high reset.
enc_a  in  1  raw encoder channel A (asynchronous, idle high).
enc_b  in  1  raw encoder channel B (asynchronous, idle high).
btn  in  1  raw push-button (asynchronous, active high).
pos  out  POS_W  current position, POS_MIN..POS_MAX.
step_cw  out  1  one-cycle pulse per clockwise detent accepted.
step_ccw  out  1  one-cycle pulse per counter-clockwise detent accepted.
btn_press  out  1  one-cycle pulse on debounced button rising edge.
btn_level  out  1  debounced button level.
at_min  out  1  pos == POS_MIN (registered with pos).
at_max  out  1  pos == POS_MAX (registered with pos).
enc_err  out  1  one-cycle pulse on an illegal quadrature transition.

Behaviour:
- Clocking and reset: one clock; rst is asynchronous and active-high.
- Reset values:
  - pos=POS_INIT; at_min/at_max match POS_INIT.
  - All pulses 0; btn_level=0.
  - Synchroniser and debounced A/B reset to 1; button synchroniser and debounced level reset to 0.
  - Debounce counters 0; quarter accumulator q=0; decoder state=2'b11.
- Synchroniser: 2 flops per input.
- Debounce: each of A, B and btn is handled independently.
  - The counter resets to 0 whenever the synchronised input equals the debounced level.
  - Otherwise the counter increments. When it reaches DB_TICKS-1, the debounced level takes the synchronised value and the counter clears.
  - A clean raw edge therefore reaches the debounced level 2+DB_TICKS cycles later.
  - A glitch shorter than DB_TICKS cycles never propagates.
- Quadrature decode: runs on the debounced pair {A,B} against its previous registered value.
  - CW sequence: 11->10->00->01->11. Each CW transition adds 1 to q (signed, 4 bits).
  - CCW sequence: the reverse. Each CCW transition subtracts 1 from q.
  - No change: q is held.
  - Both bits change in the same cycle (illegal): pulse enc_err, clear q, no step.
  - On any legal transition into 11 (detent), q clears. If the updated q equals +4, pulse step_cw; if it equals -4, pulse step_ccw; any other value gives no step (partial or reversed turn).
  - Latency: step pulse and pos update appear on the clock edge after the debounced pair becomes 11.
- Position update, on the same edge as the step pulse:
  - step_cw: pos+1 if pos<POS_MAX. At POS_MAX, pos becomes POS_MIN if WRAP=1, otherwise pos holds.
  - step_ccw: mirror of step_cw (pos-1 if pos>POS_MIN; at POS_MIN, wrap to POS_MAX if WRAP=1, otherwise hold).
  - A step pulse is still emitted when saturated; consumers use at_min/at_max to detect the limit.
- Button:
  - btn_press pulses for one cycle when the debounced level goes 0->1; nothing is emitted on release.
  - If BTN_RELOAD=1, pos loads POS_INIT on the btn_press cycle.
  - If a reload and a step occur in the same cycle, the reload wins; the step pulse is still emitted.
- Holding the button: btn_level stays 1; no repeated btn_press.
- Reset mid-rotation: q is lost. The first detent after reset needs a full 4-transition sequence.
- at_min/at_max are registered and always consistent with pos in the same cycle.

Test Plan:
All scenarios use DB_TICKS=4, POS_W=3, POS_MIN=0, POS_MAX=6, POS_INIT=3.
1. Reset, then drive one clean CW cycle with each phase held 10 cycles -> exactly one step_cw pulse; pos 3->4; enc_err never asserted.
2. WRAP=0: drive 5 CW detents from reset -> pos 4,5,6,6,6; at_max=1 from the 3rd detent; 5 step_cw pulses. Then 7 CCW detents -> pos ends at 0 and at_min=1.
3. WRAP=1: from pos=6, one CW detent -> pos=0. Then one CCW detent -> pos=6.
4. Glitch and illegal transitions:
   - Glitch enc_a low for 3 cycles -> debounced A unchanged; no pulses.
   - Change both enc_a and enc_b together and hold -> one enc_err pulse; q cleared; no step.
5. Partial and reversed turn: 11->10->00 then back 00->10->11 -> no step; pos unchanged; q returns to 0.
6. Button:
   - BTN_RELOAD=1: press with bounce (toggle every 2 cycles for 10 cycles, then hold high) at pos=5 -> single btn_press; pos=3.
   - Press coincident with a CW detent completion -> pos=3 and step_cw=1.
   - Assert rst during a held press -> btn_level=0 and pos=3 immediately.

Source files
------------

// File: rtl/rotary_encoder_ctrl.sv
// Quadrature rotary-encoder front end: 2-flop synchronisers, per-input debounce,
// full-detent quadrature decode, bounded position register and debounced push-button.
module rotary_encoder_ctrl #(
  parameter int DB_TICKS   = 250000,
  parameter int POS_W      = 3,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 6,
  parameter int POS_INIT   = 3,
  parameter int WRAP       = 0,
  parameter int BTN_RELOAD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             btn,
  output logic [POS_W-1:0] pos,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             btn_press,
  output logic             btn_level,
  output logic             at_min,
  output logic             at_max,
  output logic             enc_err
);

  localparam int CNT_W = $clog2(DB_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);
  localparam logic [POS_W-1:0] P_MIN  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] P_INIT = POS_W'(POS_INIT);

  // Channel bit order everywhere: [2] = btn, [1] = A, [0] = B. Encoder lines idle high.
  localparam logic [2:0] CH_RST = 3'b011;

  // ---------------------------------------------------------------- synchroniser
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= CH_RST;
      sync2_q <= CH_RST;
    end else begin
      sync1_q <= {btn, enc_a, enc_b};
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------- debounce
  logic [2:0]       db_q, db_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q <= CH_RST;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // ---------------------------------------------------------------- quadrature decode
  logic [1:0]        ab_cur, ab_prev_q;
  logic signed [3:0] q_q, q_d, q_step;
  logic              cw_tr, ccw_tr, bad_tr, detent;
  logic              step_cw_d, step_ccw_d, enc_err_d;

  assign ab_cur = db_q[1:0];

  always_comb begin
    cw_tr  = 1'b0;
    ccw_tr = 1'b0;
    case ({ab_prev_q, ab_cur})
      4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: cw_tr  = 1'b1;
      4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: ccw_tr = 1'b1;
      default: ;
    endcase
  end

  assign bad_tr = (ab_prev_q ^ ab_cur) == 2'b11;
  assign detent = (cw_tr || ccw_tr) && (ab_cur == 2'b11);

  always_comb begin
    q_step = q_q;
    if (cw_tr)  q_step = q_q + 4'sd1;
    if (ccw_tr) q_step = q_q - 4'sd1;
  end

  // Only a full four-quarter excursion ending on the detent counts as a step.
  always_comb begin
    q_d        = q_step;
    step_cw_d  = 1'b0;
    step_ccw_d = 1'b0;
    enc_err_d  = 1'b0;
    if (bad_tr) begin
      q_d       = '0;
      enc_err_d = 1'b1;
    end else if (detent) begin
      q_d        = '0;
      step_cw_d  = (q_step == 4'sd4);
      step_ccw_d = (q_step == -4'sd4);
    end
  end

  // ---------------------------------------------------------------- button edge
  logic btn_prev_q, btn_rise;

  assign btn_rise = db_q[2] && !btn_prev_q;

  // ---------------------------------------------------------------- position
  logic [POS_W-1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (step_cw_d) begin
      if (pos_q != P_MAX)  pos_d = pos_q + 1'b1;
      else if (WRAP != 0)  pos_d = P_MIN;
    end else if (step_ccw_d) begin
      if (pos_q != P_MIN)  pos_d = pos_q - 1'b1;
      else if (WRAP != 0)  pos_d = P_MAX;
    end
    // A reload overrides a simultaneous step; the step pulse itself still goes out.
    if ((BTN_RELOAD != 0) && btn_rise) pos_d = P_INIT;
  end

  logic step_cw_q, step_ccw_q, enc_err_q, btn_press_q, at_min_q, at_max_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ab_prev_q   <= 2'b11;
      q_q         <= '0;
      step_cw_q   <= 1'b0;
      step_ccw_q  <= 1'b0;
      enc_err_q   <= 1'b0;
      btn_prev_q  <= 1'b0;
      btn_press_q <= 1'b0;
      pos_q       <= P_INIT;
      at_min_q    <= (P_INIT == P_MIN);
      at_max_q    <= (P_INIT == P_MAX);
    end else begin
      ab_prev_q   <= ab_cur;
      q_q         <= q_d;
      step_cw_q   <= step_cw_d;
      step_ccw_q  <= step_ccw_d;
      enc_err_q   <= enc_err_d;
      btn_prev_q  <= db_q[2];
      btn_press_q <= btn_rise;
      pos_q       <= pos_d;
      at_min_q    <= (pos_d == P_MIN);
      at_max_q    <= (pos_d == P_MAX);
    end
  end

  assign pos       = pos_q;
  assign step_cw   = step_cw_q;
  assign step_ccw  = step_ccw_q;
  assign enc_err   = enc_err_q;
  assign btn_press = btn_press_q;
  assign btn_level = db_q[2];
  assign at_min    = at_min_q;
  assign at_max    = at_max_q;

endmodule

// File: tb/tb_rotary_encoder_ctrl.sv
// Bench for rotary_encoder_ctrl: a saturating and a wrapping instance share the
// same pin stimulus; each output event is checked against a queue of expected words.
module tb_rotary_encoder_ctrl;

  localparam int W = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enc_a = 1'b1;
  logic enc_b = 1'b1;
  logic btn = 1'b0;

  logic [2:0] s_pos, w_pos;
  logic s_cw, s_ccw, s_bp, s_bl, s_min, s_max, s_err;
  logic w_cw, w_ccw, w_bp, w_bl, w_min, w_max, w_err;

  int checks = 0;
  int passed = 0;

  logic [W-1:0] exp_s_q[$];
  logic [W-1:0] exp_w_q[$];

  rotary_encoder_ctrl #(
    .DB_TICKS(4), .POS_W(3), .POS_MIN(0), .POS_MAX(6), .POS_INIT(3), .WRAP(0), .BTN_RELOAD(1)
  ) u_sat (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .btn(btn),
    .pos(s_pos), .step_cw(s_cw), .step_ccw(s_ccw), .btn_press(s_bp), .btn_level(s_bl),
    .at_min(s_min), .at_max(s_max), .enc_err(s_err)
  );

  rotary_encoder_ctrl #(
    .DB_TICKS(4), .POS_W(3), .POS_MIN(0), .POS_MAX(6), .POS_INIT(3), .WRAP(1), .BTN_RELOAD(1)
  ) u_wrap (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .btn(btn),
    .pos(w_pos), .step_cw(w_cw), .step_ccw(w_ccw), .btn_press(w_bp), .btn_level(w_bl),
    .at_min(w_min), .at_max(w_max), .enc_err(w_err)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Event word: {step_cw, step_ccw, btn_press, enc_err, at_min, at_max, pos}
  function automatic logic [W-1:0] mk(input bit cw, input bit ccw, input bit bp,
                                      input bit err, input logic [2:0] p);
    return {cw, ccw, bp, err, (p == 3'd0), (p == 3'd6), p};
  endfunction

  task automatic expect_both(input bit cw, input bit ccw, input bit bp, input bit err,
                             input logic [2:0] ps, input logic [2:0] pw);
    exp_s_q.push_back(mk(cw, ccw, bp, err, ps));
    exp_w_q.push_back(mk(cw, ccw, bp, err, pw));
  endtask

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin
    if (!rst && (s_cw || s_ccw || s_bp || s_err)) begin
      if (exp_s_q.size() == 0) begin
        checks++;
        $display("FAIL sat_event: got 0x%0h, expected no event",
                 {s_cw, s_ccw, s_bp, s_err, s_min, s_max, s_pos});
      end else begin
        check("sat_event", 32'({s_cw, s_ccw, s_bp, s_err, s_min, s_max, s_pos}),
              32'(exp_s_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (w_cw || w_ccw || w_bp || w_err)) begin
      if (exp_w_q.size() == 0) begin
        checks++;
        $display("FAIL wrap_event: got 0x%0h, expected no event",
                 {w_cw, w_ccw, w_bp, w_err, w_min, w_max, w_pos});
      end else begin
        check("wrap_event", 32'({w_cw, w_ccw, w_bp, w_err, w_min, w_max, w_pos}),
              32'(exp_w_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic phase(input logic a, input logic b);
    enc_a = a;
    enc_b = b;
    wait_cycles(10);
  endtask

  task automatic cw_detent(input logic [2:0] ps, input logic [2:0] pw);
    expect_both(1'b1, 1'b0, 1'b0, 1'b0, ps, pw);
    phase(1'b1, 1'b0);
    phase(1'b0, 1'b0);
    phase(1'b0, 1'b1);
    phase(1'b1, 1'b1);
  endtask

  task automatic ccw_detent(input logic [2:0] ps, input logic [2:0] pw);
    expect_both(1'b0, 1'b1, 1'b0, 1'b0, ps, pw);
    phase(1'b0, 1'b1);
    phase(1'b0, 1'b0);
    phase(1'b1, 1'b0);
    phase(1'b1, 1'b1);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [2:0] exp_s_cw  [5] = '{3'd4, 3'd5, 3'd6, 3'd6, 3'd6};
  logic [2:0] exp_w_cw  [5] = '{3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
  logic [2:0] exp_s_ccw [7] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
  logic [2:0] exp_w_ccw [7] = '{3'd0, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
  logic [2:0] exp_s_up  [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
  logic [2:0] exp_w_up  [4] = '{3'd3, 3'd4, 3'd5, 3'd6};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sat_pos",   32'(s_pos), 32'd3);
    check("rst_wrap_pos",  32'(w_pos), 32'd3);
    check("rst_sat_flags", 32'({s_cw, s_ccw, s_bp, s_bl, s_min, s_max, s_err}), 32'd0);
    check("rst_wrap_flags", 32'({w_cw, w_ccw, w_bp, w_bl, w_min, w_max, w_err}), 32'd0);
    rst = 1'b0;
    wait_cycles(10);

    // One clean CW detent, then the rest of the CW/CCW run through both limits
    for (int i = 0; i < 5; i++) cw_detent(exp_s_cw[i], exp_w_cw[i]);
    check("sat_at_max_after_cw", 32'(s_max), 32'd1);
    for (int i = 0; i < 7; i++) ccw_detent(exp_s_ccw[i], exp_w_ccw[i]);
    check("sat_at_min_after_ccw", 32'(s_min), 32'd1);
    check("wrap_pos_after_ccw", 32'(w_pos), 32'd1);

    // Short glitch on A never reaches the debounced level
    enc_a = 1'b0;
    wait_cycles(3);
    enc_a = 1'b1;
    wait_cycles(15);
    check("glitch_sat_pos", 32'(s_pos), 32'd0);

    // Both channels move together: illegal, one error pulse, quarter count cleared
    expect_both(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd1);
    phase(1'b0, 1'b0);
    phase(1'b0, 1'b1);
    phase(1'b1, 1'b1);
    check("illegal_wrap_pos", 32'(w_pos), 32'd1);

    // Partial turn that reverses back to the detent: no step
    phase(1'b1, 1'b0);
    phase(1'b0, 1'b0);
    phase(1'b1, 1'b0);
    phase(1'b1, 1'b1);
    check("partial_sat_pos",  32'(s_pos), 32'd0);
    check("partial_wrap_pos", 32'(w_pos), 32'd1);
    cw_detent(3'd1, 3'd2);

    // Walk the saturating instance up to 5, then a bouncy button press reloads
    for (int i = 0; i < 4; i++) cw_detent(exp_s_up[i], exp_w_up[i]);
    expect_both(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 3'd3);
    for (int i = 0; i < 5; i++) begin
      btn = ~btn;
      wait_cycles(2);
    end
    btn = 1'b1;
    wait_cycles(20);
    check("held_btn_level", 32'(s_bl), 32'd1);
    btn = 1'b0;
    wait_cycles(20);
    check("released_btn_level", 32'(s_bl), 32'd0);

    // Press lands on the same edge as a CW detent: reload wins, step still pulses
    expect_both(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 3'd3);
    phase(1'b1, 1'b0);
    phase(1'b0, 1'b0);
    phase(1'b0, 1'b1);
    enc_a = 1'b1;
    enc_b = 1'b1;
    btn   = 1'b1;
    wait_cycles(20);
    btn = 1'b0;
    wait_cycles(20);

    // Reset asserted during a held press acts immediately
    expect_both(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 3'd3);
    btn = 1'b1;
    wait_cycles(20);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_sat_btn_level",  32'(s_bl),  32'd0);
    check("midrst_wrap_btn_level", 32'(w_bl),  32'd0);
    check("midrst_sat_pos",        32'(s_pos), 32'd3);
    check("midrst_wrap_pos",       32'(w_pos), 32'd3);
    wait_cycles(2);
    // Button is still held, so it debounces again after reset releases
    expect_both(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 3'd3);
    rst = 1'b0;
    wait_cycles(20);
    btn = 1'b0;
    wait_cycles(20);

    check("sat_queue_left",  32'(exp_s_q.size()), 32'd0);
    check("wrap_queue_left", 32'(exp_w_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
